alu_bit_serial_sequencer: RTL



---
 rtl/alu_bit_serial_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/alu_bit_serial_sequencer.sv
// Bit-serial ALU sequencer: steps a one-bit ALU slice LSB first and assembles a WIDTH-bit result.
// Optional zero flag enabled by defining ALU_SEQ_ZERO_FLAG_EN.
module alu_bit_serial_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [2:0]       slct,
  output logic             bit_a,
  output logic             bit_b,
  output logic             carry_in,
  input  logic             mux_bit,
  input  logic             slice_carry,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             err,
  output logic             zero
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OpSub = 3'b101;
  localparam logic [2:0] OpAdd = 3'b110;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [2:0]        op_q, op_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              carry_out_q, carry_out_d;
  logic              err_q, err_d;
  logic              arith;

  assign arith = (op_q == OpAdd) || (op_q == OpSub);

`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic zero_q, zero_d;
`endif

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    err_d       = err_q;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    zero_d      = zero_q;
`endif
    slct        = 3'b000;
    bit_a       = 1'b0;
    bit_b       = 1'b0;
    carry_in    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d         = a;
          b_d         = b;
          op_d        = opcode;
          idx_d       = '0;
          carry_d     = (opcode == OpSub);
          result_d    = '0;
          carry_out_d = 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
          zero_d      = 1'b0;
`endif
          if (opcode == 3'b010 || opcode == 3'b111) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            err_d   = 1'b0;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        busy            = 1'b1;
        slct            = op_q;
        bit_a           = a_q[idx_q];
        bit_b           = b_q[idx_q];
        carry_in        = carry_q;
        result_d[idx_q] = mux_bit;
        if (arith) carry_d = slice_carry;
        if (idx_q == IdxW'(WIDTH - 1)) begin
          // Final flags latch on entry to DONE so they are valid alongside the done pulse.
          carry_out_d = arith ? slice_carry : 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
          zero_d      = (result_d == '0);
`endif
          state_d     = StDone;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      err_q       <= err_d;
    end
  end

`ifdef ALU_SEQ_ZERO_FLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) zero_q <= 1'b0;
    else     zero_q <= zero_d;
  end
  assign zero = zero_q;
`else
  assign zero = 1'b0;
`endif

  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign err       = err_q;

endmodule
